// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, cond codes,
// instruction field positions and flag bit indices.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned NREGS   = 4;
  localparam int unsigned REG_AW  = 2;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned COND_W  = 2;
  localparam int unsigned FLAG_W  = 4;

  // Instruction field positions
  localparam int unsigned IMM_SEL_BIT = 15;
  localparam int unsigned OP_LSB      = 12;
  localparam int unsigned COND_LSB    = 10;
  localparam int unsigned RD_LSB      = 8;
  localparam int unsigned RS_LSB      = 0;
  localparam int unsigned IMM_LSB     = 0;

  // Flag bit indices within {V,N,Z,C}
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_e;

  typedef enum logic [COND_W-1:0] {
    COND_ALWAYS = 2'b00,
    COND_Z      = 2'b01,
    COND_C      = 2'b10,
    COND_N      = 2'b11
  } cond_e;

  function automatic logic cond_met(input logic [COND_W-1:0] cond,
                                    input logic [FLAG_W-1:0] fl);
    logic met;
    met = 1'b1;
    case (cond_e'(cond))
      COND_ALWAYS: met = 1'b1;
      COND_Z:      met = fl[FLAG_Z];
      COND_C:      met = fl[FLAG_C];
      COND_N:      met = fl[FLAG_N];
      default:     met = 1'b1;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4x8 register file: two async operand read ports, an async debug tap,
// one synchronous write port, async active-high reset.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] r_q [NREGS];
  logic [DATA_W-1:0] r_d [NREGS];

  always_comb begin
    for (int i = 0; i < int'(NREGS); i++) r_d[i] = r_q[i];
    if (we) r_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) r_q[i] <= r_d[i];
    end
  end

  assign rdata_a  = r_q[raddr_a];
  assign rdata_b  = r_q[raddr_b];
  assign dbg_data = r_q[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Four-state sequencer driving an external 8-bit ALU from a 4x8 register file.
// Define ALU_CTRL_COND_EN to gate writeback on cond vs. flags sampled at DECODE.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_opcode,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               alu_negative,
  input  logic               alu_overflow,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data,
  output logic [FLAG_W-1:0]  flags,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic [DATA_W-1:0]   hold_res_q, hold_res_d;
  logic [FLAG_W-1:0]   hold_flags_q, hold_flags_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                cond_ok_q, cond_ok_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                imm_sel;
  logic [OP_W-1:0]     op_f;
  logic [COND_W-1:0]   cond_f;
  logic [REG_AW-1:0]   rd_f;
  logic [REG_AW-1:0]   rs_f;
  logic [DATA_W-1:0]   imm8_f;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   rs_val;
  logic                rf_we;

  assign imm_sel = instr_q[IMM_SEL_BIT];
  assign op_f    = instr_q[OP_LSB +: OP_W];
  assign cond_f  = instr_q[COND_LSB +: COND_W];
  assign rd_f    = instr_q[RD_LSB +: REG_AW];
  assign rs_f    = instr_q[RS_LSB +: REG_AW];
  assign imm8_f  = instr_q[IMM_LSB +: DATA_W];

`ifndef ALU_CTRL_COND_EN
  logic unused_cond;
  assign unused_cond = ^cond_f;
`endif

  // Writeback commits at the end of WRITEBACK, so dbg_data shows it next cycle
  assign rf_we = (state_q == ST_WRITEBACK) && cond_ok_q;

  alu_ctrl_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd_f),
    .wdata    (hold_res_q),
    .raddr_a  (rd_f),
    .rdata_a  (rd_val),
    .raddr_b  (rs_f),
    .rdata_b  (rs_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    hold_res_d   = hold_res_q;
    hold_flags_d = hold_flags_q;
    flags_d      = flags_q;
    cond_ok_d    = cond_ok_q;
    done_d       = 1'b0;
    ready_d      = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
          ready_d = 1'b0;
        end
      end
      ST_DECODE: begin
        alu_a_d  = rd_val;
        alu_b_d  = imm_sel ? imm8_f : rs_val;
        alu_op_d = op_f;
`ifdef ALU_CTRL_COND_EN
        cond_ok_d = cond_met(cond_f, flags_q);
`else
        cond_ok_d = 1'b1;
`endif
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        hold_res_d   = alu_result;
        hold_flags_d = {alu_overflow, alu_negative, alu_zero, alu_carry};
        done_d       = 1'b1;
        state_d      = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (cond_ok_q) flags_d = hold_flags_q;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      instr_q      <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      hold_res_q   <= '0;
      hold_flags_q <= '0;
      flags_q      <= '0;
      cond_ok_q    <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      hold_res_q   <= hold_res_d;
      hold_flags_q <= hold_flags_d;
      flags_q      <= flags_d;
      cond_ok_q    <= cond_ok_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  assign instr_ready = ready_q;
  assign busy        = ~ready_q;
  assign done        = done_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_op_q;
  assign flags       = flags_q;

endmodule
